key_note_encoder: RTL and testbench

- Parametrised successor to the single-octave key decoder. Per key: synchronise and debounce raw switches. Then select one active key by a configurable policy and map it with an octave field to a note index. Output a level-style note_on/note_out pair.
- Also emits press/release events through a valid/ready FIFO for the sequencer and recorder.
- Sits between the board switch inputs and the tone generator.

---
 rtl/key_note_encoder_if.sv | 30 +++
 rtl/key_note_encoder.sv | 185 ++++++++++++++++++
 tb/tb_key_note_encoder.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/key_note_encoder_if.sv
// rtl/key_note_encoder_if.sv - key/note/event signal bundle for key_note_encoder
interface key_note_encoder_if #(
    parameter int NUM_KEYS = 8,
    parameter int OCT_W    = 1
);
    localparam int NW = OCT_W + $clog2(NUM_KEYS);

    logic                key_on;
    logic [NUM_KEYS-1:0] key;
    logic [OCT_W-1:0]    octave;
    logic [NW-1:0]       note_out;
    logic                note_on;
    logic                evt_valid;
    logic                evt_press;
    logic [NW-1:0]       evt_note;
    logic                evt_ready;
    logic                evt_overflow;

    // Board/consumer side drives switches and accepts events.
    modport master (
        output key_on, key, octave, evt_ready,
        input  note_out, note_on, evt_valid, evt_press, evt_note, evt_overflow
    );

    // Encoder side.
    modport slave (
        input  key_on, key, octave, evt_ready,
        output note_out, note_on, evt_valid, evt_press, evt_note, evt_overflow
    );
endinterface

// File: rtl/key_note_encoder.sv
// rtl/key_note_encoder.sv - debounced key selection to note index with press/release event FIFO
module key_note_encoder #(
    parameter int NUM_KEYS   = 8,
    parameter int OCT_W      = 1,
    parameter int DEB_CYCLES = 20000,
    parameter int MODE       = 0,
    parameter int EVT_DEPTH  = 4
) (
    input logic clk,
    input logic rst_n,
    key_note_encoder_if.slave bus
);
    localparam int KW = $clog2(NUM_KEYS);
    localparam int NW = OCT_W + KW;
    localparam int CW = $clog2(DEB_CYCLES);
    localparam int AW = $clog2(EVT_DEPTH);

    logic [NUM_KEYS-1:0] sync1, sync2, stable, deb_hit, rise;
    logic [CW-1:0]       deb_cnt [NUM_KEYS];
    logic [KW-1:0]       last_key, low_idx, rise_idx, sel_idx;
    logic                any_key, one_hot, sel_valid;
    logic [NW-1:0]       new_note, note_out_r;
    logic                note_on_r;

    logic [1:0]          n_push;
    logic                ev0_press;
    logic [NW-1:0]       ev0_note;

    logic [NW:0]         mem [EVT_DEPTH];
    logic [AW-1:0]       rd_ptr, wr_ptr;
    logic [AW:0]         count, cnt_after, free_slots, n_push_w, n_acc;
    logic                pop, drop, head_load, overflow;
    logic [NW:0]         head, head_next;

    // Two-flop synchroniser on the raw switch levels.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= bus.key;
            sync2 <= sync1;
        end
    end

    // A key is accepted on the edge its mismatch run reaches DEB_CYCLES.
    always_comb begin
        for (int i = 0; i < NUM_KEYS; i++) begin
            deb_hit[i] = (sync2[i] != stable[i]) && (deb_cnt[i] == CW'(DEB_CYCLES - 1));
        end
        rise = deb_hit & sync2;
    end

    // Per-key debounce counters and the stable key vector.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stable <= '0;
            for (int i = 0; i < NUM_KEYS; i++) deb_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                if (sync2[i] == stable[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_hit[i]) begin
                    stable[i]  <= sync2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + CW'(1);
                end
            end
        end
    end

    // Lowest held key and lowest newly-accepted press.
    always_comb begin
        low_idx  = '0;
        rise_idx = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (stable[i]) low_idx = KW'(i);
            if (rise[i])   rise_idx = KW'(i);
        end
        any_key = |stable;
        one_hot = any_key && ((stable & (stable - NUM_KEYS'(1))) == '0);
    end

    // Most recently pressed key, updated on the same edge the stable bit rises.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_key <= '0;
        end else if (|rise) begin
            last_key <= rise_idx;
        end
    end

    // Selection policy; key_on low suppresses any note.
    always_comb begin
        sel_idx   = low_idx;
        sel_valid = 1'b0;
        if (MODE == 0) begin
            sel_valid = one_hot;
        end else if (MODE == 1) begin
            sel_valid = any_key;
        end else begin
            sel_valid = any_key;
            if (stable[last_key]) sel_idx = last_key;
        end
        if (!bus.key_on) sel_valid = 1'b0;
        new_note = sel_valid ? {bus.octave, sel_idx} : '0;
    end

    // Registered note outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            note_on_r  <= 1'b0;
            note_out_r <= '0;
        end else begin
            note_on_r  <= sel_valid;
            note_out_r <= new_note;
        end
    end

    // Events from the note transition; a note change yields release(old) then press(new).
    always_comb begin
        n_push    = 2'd0;
        ev0_press = 1'b0;
        ev0_note  = note_out_r;
        if (!note_on_r && sel_valid) begin
            n_push    = 2'd1;
            ev0_press = 1'b1;
            ev0_note  = new_note;
        end else if (note_on_r && !sel_valid) begin
            n_push = 2'd1;
        end else if (note_on_r && sel_valid && (new_note != note_out_r)) begin
            n_push = 2'd2;
        end
    end

    // FIFO bookkeeping: pop frees space first, excess pushes drop the latest event.
    always_comb begin
        pop        = (count != '0) && bus.evt_ready;
        cnt_after  = count - (AW + 1)'(pop);
        free_slots = (AW + 1)'(EVT_DEPTH) - cnt_after;
        n_push_w   = (AW + 1)'(n_push);
        drop       = n_push_w > free_slots;
        n_acc      = drop ? free_slots : n_push_w;
        head_load  = 1'b0;
        head_next  = head;
        if (cnt_after != '0) begin
            head_load = 1'b1;
            head_next = mem[rd_ptr + AW'(pop)];
        end else if (n_acc != '0) begin
            head_load = 1'b1;
            head_next = {ev0_press, ev0_note};
        end
    end

    // FIFO storage; contents need no reset since pointers define validity.
    always_ff @(posedge clk) begin
        if (n_acc != '0)              mem[wr_ptr]          <= {ev0_press, ev0_note};
        if (n_acc >= (AW + 1)'(2))    mem[wr_ptr + AW'(1)] <= {1'b1, new_note};
    end

    // FIFO pointers, registered head and sticky overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            head     <= '0;
            overflow <= 1'b0;
        end else begin
            rd_ptr <= rd_ptr + AW'(pop);
            wr_ptr <= wr_ptr + AW'(n_acc);
            count  <= cnt_after + n_acc;
            if (head_load) head <= head_next;
            if (drop) overflow <= 1'b1;
        end
    end

    assign bus.note_on      = note_on_r;
    assign bus.note_out     = note_out_r;
    assign bus.evt_valid    = (count != '0);
    assign bus.evt_press    = head[NW];
    assign bus.evt_note     = head[NW-1:0];
    assign bus.evt_overflow = overflow;
endmodule

// File: tb/tb_key_note_encoder.sv
// tb/tb_key_note_encoder.sv - three-mode testbench with behavioural reference model
module tb_key_note_encoder;
    localparam int DEB = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_on = 1'b1;
    logic [7:0] key = 8'h00;
    logic [0:0] octave = 1'b0;
    logic       evt_ready = 1'b1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    key_note_encoder_if #(.NUM_KEYS(8), .OCT_W(1)) bus0 ();
    key_note_encoder_if #(.NUM_KEYS(8), .OCT_W(1)) bus1 ();
    key_note_encoder_if #(.NUM_KEYS(8), .OCT_W(1)) bus2 ();

    assign bus0.key_on = key_on;  assign bus0.key = key;  assign bus0.octave = octave;  assign bus0.evt_ready = evt_ready;
    assign bus1.key_on = key_on;  assign bus1.key = key;  assign bus1.octave = octave;  assign bus1.evt_ready = evt_ready;
    assign bus2.key_on = key_on;  assign bus2.key = key;  assign bus2.octave = octave;  assign bus2.evt_ready = evt_ready;

    key_note_encoder #(.NUM_KEYS(8), .OCT_W(1), .DEB_CYCLES(DEB), .MODE(0), .EVT_DEPTH(DEPTH))
        dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    key_note_encoder #(.NUM_KEYS(8), .OCT_W(1), .DEB_CYCLES(DEB), .MODE(1), .EVT_DEPTH(DEPTH))
        dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    key_note_encoder #(.NUM_KEYS(8), .OCT_W(1), .DEB_CYCLES(DEB), .MODE(2), .EVT_DEPTH(DEPTH))
        dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    // Reference model: raw levels delayed two cycles, run-length debounce,
    // selection from the accepted key set, events into a bounded list per mode.
    bit [7:0] m_s1, m_s2, m_held;
    int       m_run [8];
    int       m_last;
    int       m_on [3];
    int       m_note [3];
    int       m_fifo [3][DEPTH];
    int       m_cnt [3];
    int       m_hpress [3];
    int       m_hnote [3];
    int       m_ovf [3];

    initial begin
        m_s1 = '0; m_s2 = '0; m_held = '0; m_last = 0;
        for (int k = 0; k < 8; k++) m_run[k] = 0;
        for (int m = 0; m < 3; m++) begin
            m_on[m] = 0; m_note[m] = 0; m_cnt[m] = 0;
            m_hpress[m] = 0; m_hnote[m] = 0; m_ovf[m] = 0;
        end
    end

    always @(posedge clk) begin
        int held_n, lowest, idx, nn, ne, first_rise;
        bit v;
        int ev [2];
        if (!rst_n) begin
            m_s1 = '0; m_s2 = '0; m_held = '0; m_last = 0;
            for (int k = 0; k < 8; k++) m_run[k] = 0;
            for (int m = 0; m < 3; m++) begin
                m_on[m] = 0; m_note[m] = 0; m_cnt[m] = 0;
                m_hpress[m] = 0; m_hnote[m] = 0; m_ovf[m] = 0;
            end
        end else begin
            held_n = 0;
            lowest = 0;
            for (int k = 7; k >= 0; k--) if (m_held[k]) begin held_n++; lowest = k; end
            for (int m = 0; m < 3; m++) begin
                idx = lowest;
                if (m == 0)      v = (held_n == 1);
                else if (m == 1) v = (held_n > 0);
                else begin
                    v = (held_n > 0);
                    if (m_held[m_last]) idx = m_last;
                end
                if (!key_on) v = 0;
                nn = v ? (int'(octave) * 8 + idx) : 0;
                ne = 0;
                if (m_on[m] == 0 && v) begin
                    ev[0] = 16 + nn; ne = 1;
                end else if (m_on[m] == 1 && !v) begin
                    ev[0] = m_note[m]; ne = 1;
                end else if (m_on[m] == 1 && v && nn != m_note[m]) begin
                    ev[0] = m_note[m]; ev[1] = 16 + nn; ne = 2;
                end
                if (m_cnt[m] > 0 && evt_ready) begin
                    for (int j = 0; j < DEPTH - 1; j++) m_fifo[m][j] = m_fifo[m][j+1];
                    m_cnt[m]--;
                end
                for (int e = 0; e < ne; e++) begin
                    if (m_cnt[m] < DEPTH) begin
                        m_fifo[m][m_cnt[m]] = ev[e];
                        m_cnt[m]++;
                    end else begin
                        m_ovf[m] = 1;
                    end
                end
                if (m_cnt[m] > 0) begin
                    m_hpress[m] = m_fifo[m][0] / 16;
                    m_hnote[m]  = m_fifo[m][0] % 16;
                end
                m_on[m]   = v ? 1 : 0;
                m_note[m] = nn;
            end
            first_rise = -1;
            for (int k = 0; k < 8; k++) begin
                if (m_s2[k] == m_held[k]) m_run[k] = 0;
                else begin
                    m_run[k]++;
                    if (m_run[k] == DEB) begin
                        m_held[k] = m_s2[k];
                        m_run[k] = 0;
                        if (m_s2[k] && first_rise < 0) first_rise = k;
                    end
                end
            end
            if (first_rise >= 0) m_last = first_rise;
            m_s2 = m_s1;
            m_s1 = key;
        end
    end

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_mode(input int m, input logic on, input logic [3:0] note,
                              input logic valid, input logic press,
                              input logic [3:0] enote, input logic ovf);
        cmp($sformatf("m%0d_note_on", m), 32'(on), 32'(m_on[m]));
        cmp($sformatf("m%0d_note_out", m), 32'(note), 32'(m_note[m]));
        cmp($sformatf("m%0d_evt_valid", m), 32'(valid), 32'(m_cnt[m] > 0));
        cmp($sformatf("m%0d_evt_press", m), 32'(press), 32'(m_hpress[m]));
        cmp($sformatf("m%0d_evt_note", m), 32'(enote), 32'(m_hnote[m]));
        cmp($sformatf("m%0d_evt_overflow", m), 32'(ovf), 32'(m_ovf[m]));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        check_mode(0, bus0.note_on, bus0.note_out, bus0.evt_valid, bus0.evt_press, bus0.evt_note, bus0.evt_overflow);
        check_mode(1, bus1.note_on, bus1.note_out, bus1.evt_valid, bus1.evt_press, bus1.evt_note, bus1.evt_overflow);
        check_mode(2, bus2.note_on, bus2.note_out, bus2.evt_valid, bus2.evt_press, bus2.evt_note, bus2.evt_overflow);
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int b;
        // Reset with all keys down; then the all-keys level reaches note_on after 7 edges.
        key = 8'hFF;
        wait_ticks(3);
        cmp("rst_note_on", 32'(bus1.note_on), 0);
        cmp("rst_note_out", 32'(bus1.note_out), 0);
        cmp("rst_evt_valid", 32'(bus1.evt_valid), 0);
        cmp("rst_evt_overflow", 32'(bus2.evt_overflow), 0);
        rst_n = 1'b1;
        wait_ticks(6);
        cmp("lat_before", 32'(bus1.note_on), 0);
        tick();
        cmp("lat_note_on", 32'(bus1.note_on), 1);
        cmp("lat_note_out", 32'(bus1.note_out), 0);
        key = 8'h00;
        wait_ticks(12);

        // Glitch on key 3 produces nothing; held press gives a single press event.
        evt_ready = 1'b0;
        key = 8'h08;
        wait_ticks(2);
        key = 8'h00;
        wait_ticks(10);
        cmp("glitch_no_evt", 32'(bus0.evt_valid), 0);
        key = 8'h08;
        wait_ticks(8);
        cmp("k3_note_on", 32'(bus0.note_on), 1);
        cmp("k3_note_out", 32'(bus0.note_out), 3);
        cmp("k3_evt_press", 32'(bus0.evt_press), 1);
        cmp("k3_evt_note", 32'(bus0.evt_note), 3);
        evt_ready = 1'b1;
        tick();
        cmp("k3_single_evt", 32'(bus0.evt_valid), 0);
        key = 8'h00;
        wait_ticks(10);

        // Multi-key behaviour under the three policies.
        key = 8'h20;
        wait_ticks(10);
        key = 8'h24;
        wait_ticks(10);
        cmp("mk_m0_off", 32'(bus0.note_on), 0);
        cmp("mk_m1_note", 32'(bus1.note_out), 2);
        cmp("mk_m2_note", 32'(bus2.note_out), 2);
        key = 8'hA4;
        wait_ticks(10);
        cmp("mk_m2_k7", 32'(bus2.note_out), 7);
        cmp("mk_m1_k7", 32'(bus1.note_out), 2);
        key = 8'h24;
        wait_ticks(10);
        cmp("mk_m2_fallback", 32'(bus2.note_out), 2);
        key = 8'h00;
        wait_ticks(10);

        // Octave change while key 1 held: release 1 then press 9.
        key = 8'h02;
        wait_ticks(10);
        evt_ready = 1'b0;
        octave = 1'b1;
        tick();
        cmp("oct_note_out", 32'(bus1.note_out), 9);
        cmp("oct_head_rel", 32'(bus1.evt_press), 0);
        cmp("oct_head_rel_note", 32'(bus1.evt_note), 1);
        evt_ready = 1'b1;
        tick();
        cmp("oct_head_press", 32'(bus1.evt_press), 1);
        cmp("oct_head_press_note", 32'(bus1.evt_note), 9);
        tick();
        cmp("oct_empty", 32'(bus1.evt_valid), 0);

        // Backpressure: five events into a four-deep FIFO.
        evt_ready = 1'b0;
        octave = 1'b0;
        tick();
        octave = 1'b1;
        tick();
        key = 8'h00;
        wait_ticks(8);
        cmp("bp_overflow", 32'(bus1.evt_overflow), 1);
        cmp("bp_head0", 32'({bus1.evt_press, bus1.evt_note}), 32'h09);
        evt_ready = 1'b1;
        tick();
        cmp("bp_head1", 32'({bus1.evt_press, bus1.evt_note}), 32'h11);
        tick();
        cmp("bp_head2", 32'({bus1.evt_press, bus1.evt_note}), 32'h01);
        tick();
        cmp("bp_head3", 32'({bus1.evt_press, bus1.evt_note}), 32'h19);
        tick();
        cmp("bp_drained", 32'(bus1.evt_valid), 0);

        // key_on gating while key 4 held.
        octave = 1'b0;
        key = 8'h10;
        wait_ticks(10);
        key_on = 1'b0;
        tick();
        cmp("kon_off", 32'(bus1.note_on), 0);
        cmp("kon_rel", 32'({bus1.evt_valid, bus1.evt_press, bus1.evt_note}), 32'h24);
        key_on = 1'b1;
        tick();
        cmp("kon_on", 32'(bus1.note_out), 4);
        cmp("kon_press", 32'({bus1.evt_valid, bus1.evt_press, bus1.evt_note}), 32'h34);
        key = 8'h00;
        wait_ticks(10);

        // Reset mid-operation discards queued events.
        evt_ready = 1'b0;
        key = 8'h0F;
        wait_ticks(10);
        rst_n = 1'b0;
        tick();
        cmp("midrst_evt_valid", 32'(bus2.evt_valid), 0);
        cmp("midrst_overflow", 32'(bus1.evt_overflow), 0);
        key = 8'h00;
        rst_n = 1'b1;
        evt_ready = 1'b1;
        wait_ticks(10);

        // Randomised key activity with glitches, octave/key_on changes and backpressure.
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 5) == 0) begin
                b = $urandom_range(0, 7);
                key[b] = ~key[b];
            end
            if ($urandom_range(0, 40) == 0) octave = ~octave;
            if ($urandom_range(0, 60) == 0) key_on = ~key_on;
            evt_ready = ($urandom_range(0, 3) != 0);
            rst_n = ($urandom_range(0, 400) != 0);
            tick();
        end
        rst_n = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
